// File: rtl/sap_clock_ctrl.sv
// sap_clock_ctrl: CPU clock-enable generator for the SAP trainer.
// Three modes: MANUAL (single step per button press), AUTO (divided
// free-run) and HALTED (sticky until rst). cpu_clk_en is the only thing
// that advances the CPU; cpu_clk is a toggling copy for an LED.
// Optional build macro SAP_CLKCTRL_STEPCNT_EN adds a 16-bit step_count output.
module sap_clock_ctrl #(
  parameter int                   DIV_WIDTH = 24,
  parameter logic [DIV_WIDTH-1:0] DIV_MAX   = 24'd5_999_999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mode_auto,
  input  logic        step_req,
  input  logic        hlt,
  output logic        cpu_clk_en,
  output logic        cpu_clk,
  output logic        running,
`ifdef SAP_CLKCTRL_STEPCNT_EN
  output logic [15:0] step_count,
`endif
  output logic        halted
);

  typedef enum logic [1:0] {
    MANUAL = 2'd0,
    AUTO   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [DIV_WIDTH-1:0] div, div_nxt;
  logic                 step_q;
  logic                 step_edge;
  logic                 strobe_nxt;

  // step_q resets high so a button held through reset must be released first
  assign step_edge = step_req & ~step_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= MANUAL;
    else     state <= state_nxt;
  end

  // Next state, divider and strobe scheduling; hlt overrides everything
  always_comb begin
    state_nxt  = state;
    div_nxt    = '0;
    strobe_nxt = 1'b0;
    case (state)
      MANUAL: begin
        // divider held at 0 here, so every AUTO entry starts a full period
        if (mode_auto) state_nxt = AUTO;
        if (step_edge) strobe_nxt = 1'b1;
      end
      AUTO: begin
        if (!mode_auto) state_nxt = MANUAL;
        if (div == DIV_MAX) strobe_nxt = 1'b1;
        else                div_nxt    = div + DIV_WIDTH'(1);
      end
      HALTED: ;
      default: state_nxt = MANUAL;
    endcase
    if (hlt) begin
      state_nxt  = HALTED;
      strobe_nxt = 1'b0;
    end
  end

  // Registered datapath: divider, step history, strobe, LED clock, status
  always_ff @(posedge clk) begin
    if (rst) begin
      div        <= '0;
      step_q     <= 1'b1;
      cpu_clk_en <= 1'b0;
      cpu_clk    <= 1'b0;
      running    <= 1'b0;
      halted     <= 1'b0;
    end else begin
      div        <= div_nxt;
      step_q     <= step_req;
      cpu_clk_en <= strobe_nxt;
      cpu_clk    <= cpu_clk ^ strobe_nxt;
      // decoded from next state so status lines track the state register
      running    <= (state_nxt == AUTO);
      halted     <= (state_nxt == HALTED);
    end
  end

`ifdef SAP_CLKCTRL_STEPCNT_EN
  // Count every issued strobe; wraps naturally at 16 bits
  always_ff @(posedge clk) begin
    if (rst)             step_count <= '0;
    else if (strobe_nxt) step_count <= step_count + 16'd1;
  end
`endif

endmodule

// File: doc/sap_clock_ctrl.md
SAP_CLOCK_CTRL -- requirements
Module: sap_clock_ctrl

Interface
REQ-001 Parameter DIV_WIDTH, default 24, width of the auto-run divider counter.
REQ-002 Parameter DIV_MAX, default 24'd5_999_999, terminal count of the divider; auto period = DIV_MAX+1 clk cycles.
REQ-003 clk  input  1  system clock; all logic on its rising edge; the only clock.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 mode_auto  input  1  debounced run/step selector level; 1 = auto-run, 0 = manual step.
REQ-006 step_req  input  1  debounced step button level, active high.
REQ-007 hlt  input  1  CPU HLT control line, active high.
REQ-008 cpu_clk_en  output  1  one-cycle CPU advance strobe.
REQ-009 cpu_clk  output  1  display copy of the CPU clock, LED only.
REQ-010 running  output  1  high while in AUTO.
REQ-011 halted  output  1  high while in HALTED.

Function
REQ-012 States MANUAL, AUTO and HALTED SHALL be held in one registered state variable.
REQ-013 MANUAL -> AUTO SHALL occur when mode_auto=1; AUTO -> MANUAL SHALL occur when mode_auto=0; transitions take effect the cycle after sampling.
REQ-014 Any state -> HALTED SHALL occur when hlt=1 is sampled; HALTED SHALL be left only via rst.
REQ-015 A step edge SHALL be step_req=1 with registered previous value step_q=0; step_q SHALL update every cycle in every state.
REQ-016 In MANUAL, cpu_clk_en SHALL be high for exactly one cycle, one cycle after the edge at which the step edge is sampled; a held step_req SHALL yield one strobe only.
REQ-017 Step edges sampled in AUTO or HALTED SHALL be discarded, never queued.
REQ-018 In AUTO, the divider SHALL count 0..DIV_MAX and wrap to 0; cpu_clk_en SHALL be high for one cycle in the cycle after the counter equals DIV_MAX.
REQ-019 The divider SHALL be cleared to 0 on every entry to AUTO, in MANUAL and in HALTED; the first auto strobe SHALL occur DIV_MAX+1 cycles after AUTO entry.
REQ-020 If hlt=1 is sampled in the same cycle a strobe would be scheduled, hlt SHALL win and no strobe SHALL be issued.
REQ-021 cpu_clk SHALL toggle in the cycle each cpu_clk_en strobe is issued.
REQ-022 running and halted SHALL be registered decodes of the state variable.

Reset
REQ-023 On rst=1: state MANUAL, divider 0, step_q 1, cpu_clk_en 0, cpu_clk 0, running 0, halted 0.
REQ-024 rst SHALL override hlt, mode_auto and step_req in the same cycle.
REQ-025 Because step_q resets to 1, a step_req held high through reset release SHALL NOT produce a strobe until it falls and rises again.
REQ-026 A strobe pending when rst asserts SHALL be dropped.

Configuration
REQ-027 Macro SAP_CLKCTRL_STEPCNT_EN: when defined, adds output step_count, 16 bits; it SHALL increment on every issued cpu_clk_en, wrap 16'hFFFF -> 0, and reset to 0 with rst.
REQ-028 Without SAP_CLKCTRL_STEPCNT_EN, the step_count port and counter SHALL be absent; all other behaviour is unchanged.

Verification (DIV_MAX=3)
REQ-029 rst then mode_auto=1 held -> running=1; strobes exactly 1 cycle wide, 4 cycles apart; the first strobe 4 cycles after AUTO entry.
REQ-030 MANUAL, step_req high for 20 cycles -> exactly one strobe, 1 cycle after the first high sample; cpu_clk toggles once.
REQ-031 step_req high across rst release, then low 2 cycles, then high -> no strobe before the re-press; exactly one strobe after it.
REQ-032 AUTO, hlt=1 in the cycle the counter equals 3 -> no strobe; halted=1 next cycle; further step_req and mode changes ignored until rst.
REQ-033 AUTO, mode_auto dropped at counter=2 then raised 5 cycles later -> no strobe while in MANUAL; first strobe 4 cycles after AUTO re-entry.
REQ-034 SAP_CLKCTRL_STEPCNT_EN defined, 65537 manual steps -> step_count=1; with the macro undefined, the build has no step_count port.
